execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- EX stage of the 5-stage 16-bit pipeline. It consumes the 91-bit ID/EX buffer word, forwards operands from EX/MEM and MEM/WB, and runs the ALU.
- It owns the condition-code register (CCR) and resolves conditional jumps.
- It registers its results into an 80-bit EX/MEM buffer, which has stall and flush control.

Parameters:
- DATA_W, 16, datapath width
- PC_W, 32, program-counter width
- IDEX_W, 91, ID/EX word width
- EXMEM_W, 80, EX/MEM word width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- id_ex  in  91  ID/EX buffer word. Fields: IOR[0], IOW[1], OPS[2], ALU_OP[5:3], ALU[6], FD[8:7], Data1[24:9], Data2[40:25], WB_Address[43:41], MR[44], MW[45], WB[46], JMP[47], SP[48], SPOP[49], FGS[51:50], PC[83:52], JWSP[84], SRC_Address[87:85], IMM[88], Stack_PC[89], Stack_Flags[90]
- exmem_wb, exmem_mr  in  1  WB and MR bits of the current EX/MEM word
- exmem_addr  in  3  destination register of the EX/MEM word
- exmem_result  in  16  ALU result held in EX/MEM
- memwb_wb  in  1  write-back enable in MEM/WB
- memwb_addr  in  3  destination register in MEM/WB
- memwb_data  in  16  write-back data in MEM/WB
- flags_restore  in  1  load the CCR from flags_in (RTI pop)
- flags_in  in  3  {C,N,Z} value popped from the stack
- in_port  in  16  value of the input port, used when IOR=1
- stall  in  1  hold the EX/MEM buffer
- flush  in  1  zero the EX/MEM buffer
- exmem  out  80  EX/MEM buffer word. Fields: Result[15:0], StoreData[31:16], WB_Address[34:32], MR[35], MW[36], WB[37], IOR[38], IOW[39], SP[40], SPOP[41], JWSP[42], Stack_PC[43], Stack_Flags[44], PC[76:45], Flags[79:77]
- ccr  out  3  {C,N,Z}
- jump_taken  out  1  combinational; the jump resolves this cycle
- jump_target  out  16  combinational; the forwarded operand A

Behaviour:
- Reset (synchronous, active-high): exmem=0 and ccr=0 on the next rising edge. This overrides stall, flush and flags_restore.
- Operand A is the source register:
  - When SRC_Address==exmem_addr and exmem_wb=1 and exmem_mr=0, A=exmem_result.
  - Otherwise, when SRC_Address==memwb_addr and memwb_wb=1, A=memwb_data.
  - Otherwise A=Data1.
  - EX/MEM has priority over MEM/WB.
- Operand B is the destination register. It uses the same forwarding rule keyed on WB_Address, then the Data2 fallback. When IMM=1, B=Data2 and forwarding is not applied.
- Forwarding applies only when the ID/EX word is non-zero. A flushed bubble never matches.
- ALU, active when ALU=1. OPS=0 selects the one-operand form, which acts on B; OPS=1 selects the two-operand form.
  - 000 NOT B
  - 001 INC B
  - 010 DEC B
  - 011 ADD A+B
  - 100 SUB B−A
  - 101 AND
  - 110 OR
  - 111 MOV (result=A)
- When ALU=0: result=in_port if IOR=1, otherwise result=A. The result is used for address and store paths.
- Flags, all 16-bit:
  - Z = (result==0) and N = result[15] for ALU ops 000–110.
  - C = carry-out for INC and ADD; borrow for DEC and SUB; unchanged for logic ops.
  - MOV leaves the CCR untouched.
- FGS: 01 sets C, 10 clears C, 11 means no ALU flag update this cycle, 00 means normal. FGS has priority over ALU flag updates.
- flags_restore=1 loads the CCR from flags_in. It overrides every other same-cycle CCR update.
- Jumps: jump_taken = JMP & cond, where FD selects the condition: 00 always, 01 Z, 10 N, 11 C.
  - A taken conditional jump clears its flag in the CCR on the next edge.
  - When a conditional jump and an ALU flag write coincide, the ALU write wins. The decoder never issues both.
- The CCR updates on every edge regardless of stall; it is gated only when the ID/EX word is a bubble, which means an all-zero word.
- EX/MEM register (latency 1 cycle):
  - reset or flush → 0.
  - Otherwise, stall===0 → load the computed word. StoreData is the forwarded B; Flags is the CCR value before this instruction's update, kept for the interrupt push.
  - stall=1 → hold.
  - When flush and stall are both 1, flush wins.
  - An unknown (X) stall holds.

Decomposition:
- Shared package (pipeline_pkg): ID/EX and EX/MEM field offsets and widths, ALU_OP codes, FGS codes, FD condition codes, and flag bit indices C=2, N=1, Z=0.
- One sub-module: alu16. It takes op, A, B and ops, and produces the result, carry and a flag-write enable. It is purely combinational.
- Forwarding muxes, the CCR and the EX/MEM register live in execute_stage.

Test Plan:
- ADD with Data1=0x7FFF, Data2=0x0001, OPS=1, no forwarding → next edge exmem Result=0x8000, ccr={C=0,N=1,Z=0}.
- SUB with A=5, B=5 → Result=0, ccr Z=1; then a JZ with FD=01, JMP=1 and Data1=0x0040 → jump_taken=1, jump_target=0x0040, Z cleared on the following edge.
- EX/MEM dest=3 (WB=1, MR=0, result 0x1234) and MEM/WB dest=3 (data 0xBEEF), SRC_Address=3, MOV → Result=0x1234. Set exmem_mr=1 → Result=0xBEEF.
- stall=1 for 2 cycles with changing id_ex → exmem holds. Then flush=1 with stall=1 → exmem=0.
- INC of 0xFFFF → Result=0, C=1, Z=1. The next cycle has FGS=10 → C=0. flags_restore=1 with flags_in=3'b101 in the same cycle as an ADD → ccr=3'b101.
- reset=1 mid-stream with stall=1 → exmem=0 and ccr=0 on the next edge. Outputs stay 0 while reset is held.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ID/EX and EX/MEM field layout, ALU opcodes,
// flag-control codes, jump condition codes and CCR bit positions.
package pipeline_pkg;

    localparam int DATA_W  = 16;
    localparam int PC_W    = 32;
    localparam int IDEX_W  = 91;
    localparam int EXMEM_W = 80;

    // ID/EX word field offsets (LSB of each field)
    localparam int IDEX_IOR         = 0;
    localparam int IDEX_IOW         = 1;
    localparam int IDEX_OPS         = 2;
    localparam int IDEX_ALU_OP_LO   = 3;
    localparam int IDEX_ALU         = 6;
    localparam int IDEX_FD_LO       = 7;
    localparam int IDEX_DATA1_LO    = 9;
    localparam int IDEX_DATA2_LO    = 25;
    localparam int IDEX_WBA_LO      = 41;
    localparam int IDEX_MR          = 44;
    localparam int IDEX_MW          = 45;
    localparam int IDEX_WB          = 46;
    localparam int IDEX_JMP         = 47;
    localparam int IDEX_SP          = 48;
    localparam int IDEX_SPOP        = 49;
    localparam int IDEX_FGS_LO      = 50;
    localparam int IDEX_PC_LO       = 52;
    localparam int IDEX_JWSP        = 84;
    localparam int IDEX_SRC_LO      = 85;
    localparam int IDEX_IMM         = 88;
    localparam int IDEX_STACK_PC    = 89;
    localparam int IDEX_STACK_FLAGS = 90;

    // EX/MEM word field offsets (LSB of each field)
    localparam int EXMEM_RESULT_LO   = 0;
    localparam int EXMEM_STORE_LO    = 16;
    localparam int EXMEM_WBA_LO      = 32;
    localparam int EXMEM_MR          = 35;
    localparam int EXMEM_MW          = 36;
    localparam int EXMEM_WB          = 37;
    localparam int EXMEM_IOR         = 38;
    localparam int EXMEM_IOW         = 39;
    localparam int EXMEM_SP          = 40;
    localparam int EXMEM_SPOP        = 41;
    localparam int EXMEM_JWSP        = 42;
    localparam int EXMEM_STACK_PC    = 43;
    localparam int EXMEM_STACK_FLAGS = 44;
    localparam int EXMEM_PC_LO       = 45;
    localparam int EXMEM_FLAGS_LO    = 77;

    // CCR bit positions, CCR = {C,N,Z}
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [2:0] {
        ALU_NOT = 3'b000,
        ALU_INC = 3'b001,
        ALU_DEC = 3'b010,
        ALU_ADD = 3'b011,
        ALU_SUB = 3'b100,
        ALU_AND = 3'b101,
        ALU_OR  = 3'b110,
        ALU_MOV = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        FGS_NORMAL = 2'b00,
        FGS_SETC   = 2'b01,
        FGS_CLRC   = 2'b10,
        FGS_HOLD   = 2'b11
    } fgs_e;

    typedef enum logic [1:0] {
        FD_ALWAYS = 2'b00,
        FD_Z      = 2'b01,
        FD_N      = 2'b10,
        FD_C      = 2'b11
    } fd_e;

endpackage

// File: rtl/alu16.sv
// 16-bit combinational ALU. One-operand codes (NOT/INC/DEC) act on b;
// two-operand codes act only when ops=1, otherwise b passes through with
// no flag write (an encoding the decoder never produces).
module alu16
    import pipeline_pkg::*;
(
    input  logic [2:0]  op,
    input  logic        ops,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result,
    output logic        carry,
    output logic        flag_we,
    output logic        carry_we
);

    logic [16:0] wide;

    // Operation select; carry is carry-out for INC/ADD and borrow for DEC/SUB
    always_comb begin
        result   = b;
        carry    = 1'b0;
        flag_we  = 1'b0;
        carry_we = 1'b0;
        wide     = '0;
        case (op)
            ALU_NOT: begin
                result  = ~b;
                flag_we = 1'b1;
            end
            ALU_INC: begin
                wide     = {1'b0, b} + 17'd1;
                result   = wide[15:0];
                carry    = wide[16];
                flag_we  = 1'b1;
                carry_we = 1'b1;
            end
            ALU_DEC: begin
                wide     = {1'b0, b} - 17'd1;
                result   = wide[15:0];
                carry    = wide[16];
                flag_we  = 1'b1;
                carry_we = 1'b1;
            end
            ALU_ADD: if (ops) begin
                wide     = {1'b0, a} + {1'b0, b};
                result   = wide[15:0];
                carry    = wide[16];
                flag_we  = 1'b1;
                carry_we = 1'b1;
            end
            ALU_SUB: if (ops) begin
                wide     = {1'b0, b} - {1'b0, a};
                result   = wide[15:0];
                carry    = wide[16];
                flag_we  = 1'b1;
                carry_we = 1'b1;
            end
            ALU_AND: if (ops) begin
                result  = a & b;
                flag_we = 1'b1;
            end
            ALU_OR: if (ops) begin
                result  = a | b;
                flag_we = 1'b1;
            end
            ALU_MOV: if (ops) begin
                result = a;
            end
            default: result = b;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, ALU, condition-code register, jump
// resolution and the EX/MEM pipeline register.
module execute_stage
    import pipeline_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [IDEX_W-1:0]  id_ex,
    input  logic               exmem_wb,
    input  logic               exmem_mr,
    input  logic [2:0]         exmem_addr,
    input  logic [15:0]        exmem_result,
    input  logic               memwb_wb,
    input  logic [2:0]         memwb_addr,
    input  logic [15:0]        memwb_data,
    input  logic               flags_restore,
    input  logic [2:0]         flags_in,
    input  logic [15:0]        in_port,
    input  logic               stall,
    input  logic               flush,
    output logic [EXMEM_W-1:0] exmem,
    output logic [2:0]         ccr,
    output logic               jump_taken,
    output logic [15:0]        jump_target
);

    // ID/EX field extraction
    logic              bubble;
    logic              ior, iow, ops, alu_en, jmp, imm;
    logic [2:0]        alu_op, src_addr, wb_addr;
    logic [1:0]        fd, fgs;
    logic [DATA_W-1:0] data1, data2;
    logic [PC_W-1:0]   pc;

    assign bubble   = (id_ex == '0);
    assign ior      = id_ex[IDEX_IOR];
    assign iow      = id_ex[IDEX_IOW];
    assign ops      = id_ex[IDEX_OPS];
    assign alu_op   = id_ex[IDEX_ALU_OP_LO +: 3];
    assign alu_en   = id_ex[IDEX_ALU];
    assign fd       = id_ex[IDEX_FD_LO +: 2];
    assign data1    = id_ex[IDEX_DATA1_LO +: DATA_W];
    assign data2    = id_ex[IDEX_DATA2_LO +: DATA_W];
    assign wb_addr  = id_ex[IDEX_WBA_LO +: 3];
    assign jmp      = id_ex[IDEX_JMP];
    assign fgs      = id_ex[IDEX_FGS_LO +: 2];
    assign pc       = id_ex[IDEX_PC_LO +: PC_W];
    assign src_addr = id_ex[IDEX_SRC_LO +: 3];
    assign imm      = id_ex[IDEX_IMM];

    logic [DATA_W-1:0] op_a, op_b;

    // Forwarding: EX/MEM (non-load) beats MEM/WB; a bubble never matches
    always_comb begin
        op_a = data1;
        if (!bubble && exmem_wb && !exmem_mr && (src_addr == exmem_addr))
            op_a = exmem_result;
        else if (!bubble && memwb_wb && (src_addr == memwb_addr))
            op_a = memwb_data;

        op_b = data2;
        if (!imm) begin
            if (!bubble && exmem_wb && !exmem_mr && (wb_addr == exmem_addr))
                op_b = exmem_result;
            else if (!bubble && memwb_wb && (wb_addr == memwb_addr))
                op_b = memwb_data;
        end
    end

    logic [DATA_W-1:0] alu_result, ex_result;
    logic              alu_carry, alu_flag_we, alu_carry_we;

    alu16 u_alu (
        .op       (alu_op),
        .ops      (ops),
        .a        (op_a),
        .b        (op_b),
        .result   (alu_result),
        .carry    (alu_carry),
        .flag_we  (alu_flag_we),
        .carry_we (alu_carry_we)
    );

    assign ex_result = alu_en ? alu_result : (ior ? in_port : op_a);

    logic jump_cond;

    // Jump condition from the current CCR, selected by FD
    always_comb begin
        jump_cond = 1'b1;
        case (fd)
            FD_ALWAYS: jump_cond = 1'b1;
            FD_Z:      jump_cond = ccr[FLAG_Z];
            FD_N:      jump_cond = ccr[FLAG_N];
            FD_C:      jump_cond = ccr[FLAG_C];
            default:   jump_cond = 1'b1;
        endcase
    end

    assign jump_taken  = jmp & jump_cond;
    assign jump_target = op_a;

    logic [2:0] ccr_next;

    // CCR update order: jump clear, then ALU flags, then FGS carry control
    always_comb begin
        ccr_next = ccr;
        if (jump_taken) begin
            case (fd)
                FD_Z:    ccr_next[FLAG_Z] = 1'b0;
                FD_N:    ccr_next[FLAG_N] = 1'b0;
                FD_C:    ccr_next[FLAG_C] = 1'b0;
                default: ccr_next = ccr;
            endcase
        end
        if (alu_en && (fgs != FGS_HOLD)) begin
            if (alu_flag_we) begin
                ccr_next[FLAG_Z] = (alu_result == '0);
                ccr_next[FLAG_N] = alu_result[DATA_W-1];
            end
            if (alu_carry_we)
                ccr_next[FLAG_C] = alu_carry;
        end
        if (fgs == FGS_SETC)
            ccr_next[FLAG_C] = 1'b1;
        else if (fgs == FGS_CLRC)
            ccr_next[FLAG_C] = 1'b0;
    end

    // CCR register: ignores stall, frozen only on bubbles; RTI restore wins
    always_ff @(posedge clk) begin
        if (reset)
            ccr <= '0;
        else if (flags_restore)
            ccr <= flags_in;
        else if (!bubble)
            ccr <= ccr_next;
    end

    logic [EXMEM_W-1:0] exmem_next;

    // EX/MEM word assembly; Flags carries the pre-instruction CCR
    always_comb begin
        exmem_next = '0;
        exmem_next[EXMEM_RESULT_LO +: DATA_W] = ex_result;
        exmem_next[EXMEM_STORE_LO +: DATA_W]  = op_b;
        exmem_next[EXMEM_WBA_LO +: 3]         = wb_addr;
        exmem_next[EXMEM_MR]                  = id_ex[IDEX_MR];
        exmem_next[EXMEM_MW]                  = id_ex[IDEX_MW];
        exmem_next[EXMEM_WB]                  = id_ex[IDEX_WB];
        exmem_next[EXMEM_IOR]                 = ior;
        exmem_next[EXMEM_IOW]                 = iow;
        exmem_next[EXMEM_SP]                  = id_ex[IDEX_SP];
        exmem_next[EXMEM_SPOP]                = id_ex[IDEX_SPOP];
        exmem_next[EXMEM_JWSP]                = id_ex[IDEX_JWSP];
        exmem_next[EXMEM_STACK_PC]            = id_ex[IDEX_STACK_PC];
        exmem_next[EXMEM_STACK_FLAGS]         = id_ex[IDEX_STACK_FLAGS];
        exmem_next[EXMEM_PC_LO +: PC_W]       = pc;
        exmem_next[EXMEM_FLAGS_LO +: 3]       = ccr;
    end

    // EX/MEM register: flush beats stall; only a definite stall==0 loads
    always_ff @(posedge clk) begin
        if (reset || flush)
            exmem <= '0;
        else if (stall == 1'b0)
            exmem <= exmem_next;
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed and randomized bench for execute_stage with a behavioural model.
module tb_execute_stage;
    import pipeline_pkg::*;

    typedef struct packed {
        logic        stack_flags;
        logic        stack_pc;
        logic        imm;
        logic [2:0]  src;
        logic        jwsp;
        logic [31:0] pc;
        logic [1:0]  fgs;
        logic        spop;
        logic        sp;
        logic        jmp;
        logic        wb;
        logic        mw;
        logic        mr;
        logic [2:0]  wb_addr;
        logic [15:0] data2;
        logic [15:0] data1;
        logic [1:0]  fd;
        logic        alu;
        logic [2:0]  alu_op;
        logic        ops;
        logic        iow;
        logic        ior;
    } idex_t;

    typedef struct packed {
        logic [2:0]  flags;
        logic [31:0] pc;
        logic        stack_flags;
        logic        stack_pc;
        logic        jwsp;
        logic        spop;
        logic        sp;
        logic        iow;
        logic        ior;
        logic        wb;
        logic        mw;
        logic        mr;
        logic [2:0]  wb_addr;
        logic [15:0] store;
        logic [15:0] result;
    } exmem_t;

    logic        clk = 1'b0;
    logic        reset;
    idex_t       w;
    logic [90:0] id_ex;
    logic        exmem_wb, exmem_mr, memwb_wb;
    logic [2:0]  exmem_addr, memwb_addr, flags_in;
    logic [15:0] exmem_result, memwb_data, in_port;
    logic        flags_restore, stall, flush;
    logic [79:0] dut_exmem;
    logic [2:0]  ccr;
    logic        jump_taken;
    logic [15:0] jump_target;

    assign id_ex = w;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk           (clk),
        .reset         (reset),
        .id_ex         (id_ex),
        .exmem_wb      (exmem_wb),
        .exmem_mr      (exmem_mr),
        .exmem_addr    (exmem_addr),
        .exmem_result  (exmem_result),
        .memwb_wb      (memwb_wb),
        .memwb_addr    (memwb_addr),
        .memwb_data    (memwb_data),
        .flags_restore (flags_restore),
        .flags_in      (flags_in),
        .in_port       (in_port),
        .stall         (stall),
        .flush         (flush),
        .exmem         (dut_exmem),
        .ccr           (ccr),
        .jump_taken    (jump_taken),
        .jump_target   (jump_target)
    );

    int tests = 0;
    int fails = 0;

    exmem_t      exp_exmem;
    logic [2:0]  exp_ccr;
    exmem_t      m_exmem;
    logic [2:0]  m_ccr_next;
    logic [15:0] m_a, m_b;
    logic        m_jump;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] fwd_val(input logic [2:0] key, input logic [15:0] dflt,
                                            input logic active);
        if (active && exmem_wb && !exmem_mr && key == exmem_addr) return exmem_result;
        if (active && memwb_wb && key == memwb_addr) return memwb_data;
        return dflt;
    endfunction

    // Reference model of one instruction, from the current inputs and exp_ccr
    task automatic predict();
        logic        active, upd_zn, upd_c, c_val, cond;
        logic [15:0] r;
        int          s;
        logic [2:0]  n;
        active = (w != '0);
        m_a = fwd_val(w.src, w.data1, active);
        m_b = w.imm ? w.data2 : fwd_val(w.wb_addr, w.data2, active);
        upd_zn = 1'b0; upd_c = 1'b0; c_val = 1'b0; r = m_a;
        if (w.alu) begin
            case (w.alu_op)
                3'd0: begin r = ~m_b; upd_zn = 1'b1; end
                3'd1: begin s = int'(m_b) + 1; r = 16'(s); c_val = (s > 65535); upd_zn = 1'b1; upd_c = 1'b1; end
                3'd2: begin r = m_b - 16'd1; c_val = (m_b == 16'd0); upd_zn = 1'b1; upd_c = 1'b1; end
                3'd3: begin s = int'(m_a) + int'(m_b); r = 16'(s); c_val = (s > 65535); upd_zn = 1'b1; upd_c = 1'b1; end
                3'd4: begin r = m_b - m_a; c_val = (m_a > m_b); upd_zn = 1'b1; upd_c = 1'b1; end
                3'd5: begin r = m_a & m_b; upd_zn = 1'b1; end
                3'd6: begin r = m_a | m_b; upd_zn = 1'b1; end
                default: r = m_a;
            endcase
        end else begin
            r = w.ior ? in_port : m_a;
        end
        case (w.fd)
            2'd1:    cond = exp_ccr[0];
            2'd2:    cond = exp_ccr[1];
            2'd3:    cond = exp_ccr[2];
            default: cond = 1'b1;
        endcase
        m_jump = w.jmp & cond;
        n = exp_ccr;
        if (active) begin
            if (m_jump && w.fd != 2'd0) n[int'(w.fd) - 1] = 1'b0;
            if (w.alu && w.fgs != 2'd3) begin
                if (upd_zn) begin n[0] = (r == 16'd0); n[1] = r[15]; end
                if (upd_c) n[2] = c_val;
            end
            if (w.fgs == 2'd1) n[2] = 1'b1;
            if (w.fgs == 2'd2) n[2] = 1'b0;
        end
        if (flags_restore) n = flags_in;
        m_ccr_next = n;
        m_exmem = '0;
        m_exmem.result      = r;
        m_exmem.store       = m_b;
        m_exmem.wb_addr     = w.wb_addr;
        m_exmem.mr          = w.mr;
        m_exmem.mw          = w.mw;
        m_exmem.wb          = w.wb;
        m_exmem.ior         = w.ior;
        m_exmem.iow         = w.iow;
        m_exmem.sp          = w.sp;
        m_exmem.spop        = w.spop;
        m_exmem.jwsp        = w.jwsp;
        m_exmem.stack_pc    = w.stack_pc;
        m_exmem.stack_flags = w.stack_flags;
        m_exmem.pc          = w.pc;
        m_exmem.flags       = exp_ccr;
    endtask

    // One clock: check combinational jump outputs, clock, check registers
    task automatic run_cycle(input string tag);
        #1;
        predict();
        check({tag, ".jump_taken"}, 80'(jump_taken), 80'(m_jump));
        check({tag, ".jump_target"}, 80'(jump_target), 80'(m_a));
        @(posedge clk);
        #1;
        if (reset) begin
            exp_exmem = '0;
            exp_ccr   = 3'b000;
        end else begin
            exp_ccr = m_ccr_next;
            if (flush) exp_exmem = '0;
            else if (!stall) exp_exmem = m_exmem;
        end
        check({tag, ".exmem"}, dut_exmem, exp_exmem);
        check({tag, ".ccr"}, 80'(ccr), 80'(exp_ccr));
    endtask

    function automatic idex_t mk(input logic [2:0] op, input logic alu, input logic [15:0] d1,
                                 input logic [15:0] d2, input logic [2:0] src, input logic [2:0] dst);
        idex_t t = '0;
        t.alu_op  = op;
        t.alu     = alu;
        t.ops     = (op >= 3'd3);
        t.data1   = d1;
        t.data2   = d2;
        t.src     = src;
        t.wb_addr = dst;
        t.wb      = 1'b1;
        t.pc      = 32'h0000_0100;
        return t;
    endfunction

    function automatic idex_t rand_idex();
        logic [95:0] raw;
        idex_t       t;
        raw = {$urandom, $urandom, $urandom};
        t = raw[90:0];
        t.src     = 3'($urandom_range(0, 3));
        t.wb_addr = 3'($urandom_range(0, 3));
        t.ops     = (t.alu_op >= 3'd3);
        t.imm     = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 3) == 0) t.data2 = 16'hFFFF;
        if ($urandom_range(0, 3) == 0) t.data1 = t.data2;
        if ($urandom_range(0, 9) == 0) t = '0;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exmem_t got;
        exmem_t held;
        reset = 1'b1; w = '0;
        exmem_wb = 1'b0; exmem_mr = 1'b0; exmem_addr = 3'd0; exmem_result = 16'd0;
        memwb_wb = 1'b0; memwb_addr = 3'd0; memwb_data = 16'd0;
        flags_restore = 1'b0; flags_in = 3'd0; in_port = 16'd0;
        stall = 1'b0; flush = 1'b0;
        exp_exmem = '0; exp_ccr = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check("reset.exmem", dut_exmem, 80'd0);
        check("reset.ccr", 80'(ccr), 80'd0);
        reset = 1'b0;

        // ADD 0x7FFF + 0x0001
        w = mk(3'd3, 1'b1, 16'h7FFF, 16'h0001, 3'd1, 3'd2);
        run_cycle("add");
        got = dut_exmem;
        check("add.result", 80'(got.result), 80'h8000);
        check("add.ccr", 80'(ccr), 80'(3'b010));

        // SUB 5 - 5, then JZ
        w = mk(3'd4, 1'b1, 16'd5, 16'd5, 3'd1, 3'd2);
        run_cycle("sub");
        got = dut_exmem;
        check("sub.result", 80'(got.result), 80'h0);
        check("sub.ccr", 80'(ccr), 80'(3'b001));
        w = mk(3'd0, 1'b0, 16'h0040, 16'd0, 3'd1, 3'd2);
        w.jmp = 1'b1; w.fd = 2'd1; w.wb = 1'b0;
        #1;
        check("jz.taken", 80'(jump_taken), 80'd1);
        check("jz.target", 80'(jump_target), 80'h0040);
        run_cycle("jz");
        check("jz.zclear", 80'(ccr), 80'(3'b000));

        // Forwarding priority
        exmem_wb = 1'b1; exmem_mr = 1'b0; exmem_addr = 3'd3; exmem_result = 16'h1234;
        memwb_wb = 1'b1; memwb_addr = 3'd3; memwb_data = 16'hBEEF;
        w = mk(3'd7, 1'b1, 16'd0, 16'd0, 3'd3, 3'd4);
        run_cycle("fwd_ex");
        got = dut_exmem;
        check("fwd_ex.result", 80'(got.result), 80'h1234);
        exmem_mr = 1'b1;
        run_cycle("fwd_mw");
        got = dut_exmem;
        check("fwd_mw.result", 80'(got.result), 80'hBEEF);
        exmem_wb = 1'b0; memwb_wb = 1'b0; exmem_mr = 1'b0;

        // Stall holds, flush wins over stall
        held = exp_exmem;
        stall = 1'b1;
        w = mk(3'd5, 1'b1, 16'h0F0F, 16'h00FF, 3'd1, 3'd2);
        run_cycle("stall1");
        w = mk(3'd6, 1'b1, 16'hF000, 16'h000F, 3'd2, 3'd1);
        run_cycle("stall2");
        check("stall.hold", dut_exmem, held);
        flush = 1'b1;
        run_cycle("flush");
        check("flush.zero", dut_exmem, 80'd0);
        stall = 1'b0; flush = 1'b0;

        // INC wrap, FGS clear carry, flags_restore override
        w = mk(3'd1, 1'b1, 16'd0, 16'hFFFF, 3'd1, 3'd5);
        run_cycle("inc");
        got = dut_exmem;
        check("inc.result", 80'(got.result), 80'h0);
        check("inc.ccr", 80'(ccr), 80'(3'b101));
        w = mk(3'd0, 1'b0, 16'd7, 16'd0, 3'd1, 3'd5);
        w.fgs = 2'd2;
        run_cycle("fgs_clrc");
        check("fgs_clrc.ccr", 80'(ccr), 80'(3'b001));
        w = mk(3'd3, 1'b1, 16'd1, 16'd2, 3'd1, 3'd2);
        flags_restore = 1'b1; flags_in = 3'b101;
        run_cycle("restore");
        check("restore.ccr", 80'(ccr), 80'(3'b101));
        flags_restore = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            w = rand_idex();
            exmem_wb      = 1'($urandom_range(0, 1));
            exmem_mr      = ($urandom_range(0, 3) == 0);
            exmem_addr    = 3'($urandom_range(0, 3));
            exmem_result  = 16'($urandom);
            memwb_wb      = 1'($urandom_range(0, 1));
            memwb_addr    = 3'($urandom_range(0, 3));
            memwb_data    = 16'($urandom);
            in_port       = 16'($urandom);
            stall         = ($urandom_range(0, 7) == 0);
            flush         = ($urandom_range(0, 15) == 0);
            flags_restore = ($urandom_range(0, 15) == 0);
            flags_in      = 3'($urandom_range(0, 7));
            run_cycle("rand");
        end

        // Reset mid-stream with stall asserted
        flush = 1'b0; flags_restore = 1'b1; flags_in = 3'b111;
        stall = 1'b1; reset = 1'b1;
        w = mk(3'd3, 1'b1, 16'h7FFF, 16'h7FFF, 3'd1, 3'd2);
        run_cycle("rst1");
        check("rst1.exmem", dut_exmem, 80'd0);
        check("rst1.ccr", 80'(ccr), 80'd0);
        stall = 1'b0;
        run_cycle("rst2");
        run_cycle("rst3");
        reset = 1'b0; flags_restore = 1'b0;
        exmem_wb = 1'b0; memwb_wb = 1'b0;
        w = mk(3'd3, 1'b1, 16'h0003, 16'h0004, 3'd1, 3'd2);
        run_cycle("post_rst");
        got = dut_exmem;
        check("post_rst.result", 80'(got.result), 80'h7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
